match_game_ctrl: RTL

- Parametrised, multi-level successor to the DE2-115 matching game.
- Generates a pseudo-random lamp pattern for each level and extinguishes a lamp when its switch is raised.
- Runs a per-level BCD countdown timer with pause, and sequences levels through a state machine to a win or lose end state.
- Sits between the switch/key inputs, which are synchronised and debounced upstream, and the LED and 7-segment decoders.

---
 rtl/match_game_if.sv | 28 ++
 rtl/match_game_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/match_game_if.sv
// Player-facing signal bundle for the matching game.
// The player drives the inputs; the controller drives lamps, flags and digits.
interface match_game_if #(
  parameter int N_CELLS = 14
);
  logic               start;
  logic               pause;
  logic [N_CELLS-1:0] sw;
  logic [N_CELLS-1:0] led_pattern;
  logic               go;
  logic               win;
  logic               lose;
  logic [3:0]         level;
  logic [3:0]         secs_ones;
  logic [3:0]         secs_tens;

  modport master (
    output start, pause, sw,
    input  led_pattern, go, win, lose,
    input  level, secs_ones, secs_tens
  );

  modport slave (
    input  start, pause, sw,
    output led_pattern, go, win, lose,
    output level, secs_ones, secs_tens
  );
endinterface

// File: rtl/match_game_ctrl.sv
// Multi-level lamp matching game controller.
// Random pattern per level, BCD countdown with pause, win/lose sequencing.
module match_game_ctrl #(
  parameter int N_CELLS       = 14,
  parameter int N_LEVELS      = 4,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TIME_LIMIT    = 30,
  parameter int TIME_STEP     = 5,
  parameter int MIN_TIME      = 5
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  match_game_if.slave  gi
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    PLAY,
    CLEAR,
    WIN,
    LOSE
  } state_t;

  localparam int CW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TICK_MAX =
    CW'(TICKS_PER_SEC - 1);
  localparam logic [N_CELLS-1:0] ALL_ON = '1;
  localparam logic [3:0] LAST = 4'(N_LEVELS - 1);
  localparam logic [6:0] T0   = 7'(TIME_LIMIT);

  // Level time, saturating at zero then floored.
  function automatic logic [6:0] lim(
    input logic [3:0] l
  );
    logic [11:0] prod;
    logic [7:0]  dec;
    logic [7:0]  t;
    prod = 12'(l) * 12'(TIME_STEP);
    dec  = (prod > 12'd255) ? 8'hFF : prod[7:0];
    if (dec >= 8'(TIME_LIMIT))
      t = 8'd0;
    else
      t = 8'(TIME_LIMIT) - dec;
    if (t < 8'(MIN_TIME))
      t = 8'(MIN_TIME);
    return 7'(t);
  endfunction

  state_t             state_q, state_n;
  logic [3:0]         level_q, level_n;
  logic [N_CELLS-1:0] pat_q, pat_n;
  logic [6:0]         secs_q, secs_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [15:0]        lfsr_q;
  logic               fb;
  logic               tick;
  logic               match;
  logic [N_CELLS-1:0] seed;
  logic [N_CELLS-1:0] led_n;
  logic [3:0]         ones_n, tens_n;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];

  assign seed = lfsr_q[N_CELLS-1:0];

  assign tick = (state_q == PLAY)
             && !gi.pause
             && (cnt_q == TICK_MAX);

  assign match = (gi.sw == pat_q);

  // Free-running pattern source, stepped every cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)
      lfsr_q <= 16'hACE1;
    else
      lfsr_q <= {lfsr_q[14:0], fb};
  end

  // Next state, level, pattern, timer and tick counter.
  always_comb begin
    state_n = state_q;
    level_n = level_q;
    pat_n   = pat_q;
    secs_n  = secs_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        secs_n = lim(level_q);
        if (gi.start)
          state_n = LOAD;
      end
      LOAD: begin
        pat_n = (seed == '0)
              ? N_CELLS'(1) : seed;
        secs_n  = lim(level_q);
        state_n = ARM;
      end
      ARM: begin
        if (gi.sw == '0) begin
          state_n = PLAY;
          cnt_n   = '0;
        end
      end
      PLAY: begin
        if (!gi.pause)
          cnt_n = tick ? '0 : cnt_q + 1'b1;
        if (match) begin
          state_n = CLEAR;
        end else if (tick) begin
          if (secs_q == 7'd1) begin
            state_n = LOSE;
            secs_n  = 7'd0;
          end else begin
            secs_n = secs_q - 7'd1;
          end
        end
      end
      CLEAR: begin
        if (level_q == LAST) begin
          state_n = WIN;
        end else if (gi.start) begin
          level_n = level_q + 4'd1;
          state_n = LOAD;
        end
      end
      WIN, LOSE: begin
        if (gi.start) begin
          state_n = IDLE;
          level_n = 4'd0;
          secs_n  = lim(4'd0);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output values derived from the upcoming state.
  always_comb begin
    led_n = '0;
    unique case (state_n)
      ARM:         led_n = pat_n;
      PLAY:        led_n = pat_n & ~gi.sw;
      CLEAR, WIN:  led_n = ALL_ON;
      LOSE:        led_n = pat_n;
      default:     led_n = '0;
    endcase
    tens_n = 4'(secs_n / 7'd10);
    ones_n = 4'(secs_n % 7'd10);
  end

  // Core state registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= 4'd0;
      pat_q   <= '0;
      secs_q  <= T0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      level_q <= level_n;
      pat_q   <= pat_n;
      secs_q  <= secs_n;
      cnt_q   <= cnt_n;
    end
  end

  // Registered outputs, aligned with the state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      gi.led_pattern <= '0;
      gi.go          <= 1'b0;
      gi.win         <= 1'b0;
      gi.lose        <= 1'b0;
      gi.level       <= 4'd0;
      gi.secs_tens   <= 4'(T0 / 7'd10);
      gi.secs_ones   <= 4'(T0 % 7'd10);
    end else begin
      gi.led_pattern <= led_n;
      gi.go          <= (state_n == PLAY);
      gi.win         <= (state_n == WIN);
      gi.lose        <= (state_n == LOSE);
      gi.level       <= level_n;
      gi.secs_tens   <= tens_n;
      gi.secs_ones   <= ones_n;
    end
  end

endmodule
